// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {address, ~address, command, ~command}
// as a pulse-distance frame (lead mark/space, 32 bits, stop mark, gap) and
// drives both the raw envelope and a carrier-modulated LED output.
module ir_nec_tx #(
    parameter int TICK_CYCLES      = 1750,
    parameter int LEAD_MARK_TICKS  = 257,
    parameter int LEAD_SPACE_TICKS = 128,
    parameter int BIT_MARK_TICKS   = 16,
    parameter int ZERO_SPACE_TICKS = 16,
    parameter int ONE_SPACE_TICKS  = 48,
    parameter int GAP_TICKS        = 1143,
    parameter int CARRIER_HALF     = 658
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       irEnv,
    output logic       irOut
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] CAR_LAST = HW'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cyc_reg;
    logic [15:0]     tick_reg;
    logic [5:0]      idx_reg;
    logic [31:0]     shreg_reg;
    logic [HW-1:0]   car_cnt_reg;
    logic            car_ph_reg;

    logic [15:0]     seg_ticks;
    logic            seg_end;
    logic            car_wrap;

    // Length of the current segment in ticks; bit spaces depend on the bit being sent
    always_comb begin
        seg_ticks = 16'd1;
        case (state_reg)
            LEAD_MARK:  seg_ticks = 16'(LEAD_MARK_TICKS);
            LEAD_SPACE: seg_ticks = 16'(LEAD_SPACE_TICKS);
            BIT_MARK:   seg_ticks = 16'(BIT_MARK_TICKS);
            BIT_SPACE:  seg_ticks = shreg_reg[31] ? 16'(ONE_SPACE_TICKS) : 16'(ZERO_SPACE_TICKS);
            STOP_MARK:  seg_ticks = 16'(BIT_MARK_TICKS);
            GAP:        seg_ticks = 16'(GAP_TICKS);
            default:    seg_ticks = 16'd1;
        endcase
    end

    assign seg_end  = (cyc_reg == CYC_LAST) && (tick_reg == seg_ticks - 16'd1);
    assign car_wrap = (car_cnt_reg == CAR_LAST);

    // Frame sequencer, segment timer, carrier generator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cyc_reg     <= '0;
            tick_reg    <= '0;
            idx_reg     <= '0;
            shreg_reg   <= '0;
            car_cnt_reg <= '0;
            car_ph_reg  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            irEnv       <= 1'b0;
            irOut       <= 1'b0;
        end else begin
            done <= 1'b0;

            // free-running carrier; restarted below on every mark entry
            if (car_wrap) begin
                car_cnt_reg <= '0;
                car_ph_reg  <= ~car_ph_reg;
            end else begin
                car_cnt_reg <= car_cnt_reg + 1'b1;
            end
            irOut <= irEnv & (car_wrap ? ~car_ph_reg : car_ph_reg);

            // segment timer runs only while a frame is in flight
            if (state_reg != IDLE) begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_reg  <= '0;
                    tick_reg <= tick_reg + 16'd1;
                end else begin
                    cyc_reg <= cyc_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= LEAD_MARK;
                        shreg_reg   <= {address, ~address, command, ~command};
                        busy        <= 1'b1;
                        cyc_reg     <= '0;
                        tick_reg    <= '0;
                        irEnv       <= 1'b1;
                        irOut       <= 1'b1;
                        car_cnt_reg <= '0;
                        car_ph_reg  <= 1'b1;
                    end
                end
                LEAD_MARK: begin
                    if (seg_end) begin
                        state_reg <= LEAD_SPACE;
                        cyc_reg   <= '0;
                        tick_reg  <= '0;
                        irEnv     <= 1'b0;
                        irOut     <= 1'b0;
                    end
                end
                LEAD_SPACE: begin
                    if (seg_end) begin
                        state_reg   <= BIT_MARK;
                        idx_reg     <= '0;
                        cyc_reg     <= '0;
                        tick_reg    <= '0;
                        irEnv       <= 1'b1;
                        irOut       <= 1'b1;
                        car_cnt_reg <= '0;
                        car_ph_reg  <= 1'b1;
                    end
                end
                BIT_MARK: begin
                    if (seg_end) begin
                        state_reg <= BIT_SPACE;
                        cyc_reg   <= '0;
                        tick_reg  <= '0;
                        irEnv     <= 1'b0;
                        irOut     <= 1'b0;
                    end
                end
                BIT_SPACE: begin
                    if (seg_end) begin
                        state_reg   <= (idx_reg == 6'd31) ? STOP_MARK : BIT_MARK;
                        shreg_reg   <= {shreg_reg[30:0], 1'b0};
                        idx_reg     <= idx_reg + 6'd1;
                        cyc_reg     <= '0;
                        tick_reg    <= '0;
                        irEnv       <= 1'b1;
                        irOut       <= 1'b1;
                        car_cnt_reg <= '0;
                        car_ph_reg  <= 1'b1;
                    end
                end
                STOP_MARK: begin
                    if (seg_end) begin
                        state_reg <= GAP;
                        cyc_reg   <= '0;
                        tick_reg  <= '0;
                        irEnv     <= 1'b0;
                        irOut     <= 1'b0;
                    end
                end
                GAP: begin
                    if (seg_end) begin
                        state_reg <= IDLE;
                        cyc_reg   <= '0;
                        tick_reg  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    irEnv     <= 1'b0;
                    irOut     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx with short timing (4 clk per tick, 2 clk carrier half):
// decodes each frame from irEnv, checks segment lengths, data word, carrier
// shape, gap length, done pulse and reset abort.
module tb_ir_nec_tx;

    localparam int TICK = 4;
    localparam int CH   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] command = 8'h00;
    logic       busy, done, irEnv, irOut;

    int checks = 0;
    int errors = 0;
    int car_bad = 0;
    int done_count = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [2];

    ir_nec_tx #(
        .TICK_CYCLES(TICK),
        .CARRIER_HALF(CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .address(address),
        .command(command),
        .busy(busy),
        .done(done),
        .irEnv(irEnv),
        .irOut(irOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // count consecutive negedge samples at level lvl, checking the carrier shape
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (irEnv === lvl && n < 5000) begin
            if (lvl) begin
                if (irOut !== (((n / CH) % 2) == 0)) car_bad++;
            end else begin
                if (irOut !== 1'b0) car_bad++;
            end
            n++;
            @(negedge clk);
        end
    endtask

    // receive and check one complete frame; returns at the done-pulse sample
    task automatic recv_frame(input string tag, input logic [31:0] exp_word, input int exp_wait);
        int n, m, s, mark_bad, space_bad;
        logic [31:0] word;
        n = 0;
        while (irEnv !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_start_wait"}, n, exp_wait);
        car_bad = 0;
        measure(1'b1, m);
        check({tag, "_lead_mark"}, m, 32'd1028);
        measure(1'b0, s);
        check({tag, "_lead_space"}, s, 32'd512);
        mark_bad = 0;
        space_bad = 0;
        word = '0;
        for (int i = 0; i < 32; i++) begin
            measure(1'b1, m);
            if (m != 64) mark_bad++;
            measure(1'b0, s);
            if (s == 192) word = {word[30:0], 1'b1};
            else begin
                word = {word[30:0], 1'b0};
                if (s != 64) space_bad++;
            end
        end
        check({tag, "_bit_mark_len"}, mark_bad, 0);
        check({tag, "_bit_space_len"}, space_bad, 0);
        check({tag, "_word"}, word, exp_word);
        measure(1'b1, m);
        check({tag, "_stop_mark"}, m, 32'd64);
        n = 0;
        while (busy === 1'b1 && done === 1'b0 && irEnv === 1'b0 && n < 6000) begin
            if (irOut !== 1'b0) car_bad++;
            n++;
            @(negedge clk);
        end
        check({tag, "_gap"}, n, 32'd4572);
        check({tag, "_done_pulse"}, done, 1'b1);
        check({tag, "_busy_drop"}, busy, 1'b0);
        check({tag, "_carrier"}, car_bad, 0);
        $display("frame %s: word=%08h expected=%08h", tag, word, exp_word);
    endtask

    initial begin
        int bad, d0, falls, n;
        logic prev;

        vecs[0] = '{8'h00, 8'h62, 32'h00FF629D};
        vecs[1] = '{8'h5A, 8'h3C, 32'h5AA53CC3};

        // 1: reset state, then idle quiet with start low
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_irEnv", irEnv, 1'b0);
        check("reset_irOut", irOut, 1'b0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy || done || irEnv || irOut) bad++;
        end
        check("idle_quiet", bad, 0);
        $display("idle: 100 cycles with start low, active samples=%0d", bad);

        // 2: table-driven single frames
        for (int v = 0; v < 2; v++) begin
            address = vecs[v].addr;
            command = vecs[v].cmd;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            recv_frame($sformatf("vec%0d", v), vecs[v].exp_word, 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_single", v), done, 1'b0);
        end

        // 3+4: start held; inputs change mid-frame; frames back-to-back
        d0 = done_count;
        address = 8'h00;
        command = 8'hE2;
        start = 1'b1;
        @(negedge clk);
        fork
            recv_frame("held0", 32'h00FFE21D, 0);
            begin
                repeat (2000) @(negedge clk);
                address = 8'hFF;
                command = 8'hFF;
            end
        join
        @(negedge clk);
        recv_frame("held1", 32'hFF00FF00, 0);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irEnv || busy) bad++;
        end
        check("held_release_idle", bad, 0);
        check("held_done_count", done_count - d0, 2);

        // 5: reset during bit 10's space, then a complete frame
        address = 8'h00;
        command = 8'hE2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        falls = 0;
        n = 0;
        prev = irEnv;
        while (falls < 12 && n < 20000) begin
            @(negedge clk);
            if (prev && !irEnv) falls++;
            prev = irEnv;
            n++;
        end
        check("abort_reach_bit10", falls, 12);
        repeat (20) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        d0 = done_count;
        #2 rst = 1'b1;
        #1;
        check("abort_irEnv", irEnv, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_irOut", irOut, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_count, d0);
        $display("abort: reset asserted in bit 10 space, busy=%0d irEnv=%0d", busy, irEnv);
        command = 8'hA2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recv_frame("after_abort", 32'h00FFA25D, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
